// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a KMP-style transition table,
// selectable overlap and Moore/Mealy output, and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter bit MOORE = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);
  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int TW = 2 * (PAT_LEN + 1) * SW;
  typedef logic [SW-1:0] st_t;
  typedef logic [2*PAT_LEN+1:0][SW-1:0] tbl_t;
  if ((PAT_LEN < 1) || (PAT_LEN > 32)) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN must be in 1..32");
  end
  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pat_bit(int i);
    logic [PAT_LEN-1:0] p;
    p = PATTERN >> (PAT_LEN - 1 - i);
    return p[0];
  endfunction
  // Longest pattern prefix that is a suffix of (prefix of length s) followed by b.
  function automatic int delta(int s, logic b);
    int best;
    logic ok;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++)
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (((s + 1 - k + j == s) ? b : pat_bit(s + 1 - k + j)) != pat_bit(j)) ok = 1'b0;
        if (ok) best = k;
      end
    return best;
  endfunction
  function automatic int fail_len();
    int best;
    logic ok;
    best = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (pat_bit(PAT_LEN - k + j) != pat_bit(j)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction
  // Without overlap the full state restarts, so it borrows state 0's transitions.
  function automatic logic [TW-1:0] build_table();
    logic [TW-1:0] t;
    t = '0;
    for (int s = 0; s <= PAT_LEN; s++)
      for (int b = 0; b < 2; b++)
        t = t | (TW'(delta((!OVERLAP && s == PAT_LEN) ? 0 : s, b[0])) << (SW * (2 * s + b)));
    return t;
  endfunction
  localparam tbl_t TBL = build_table();
  localparam st_t FULL = st_t'(PAT_LEN);
  localparam st_t FAIL = st_t'(fail_len());
  st_t st, st_nxt, nxt_raw;
  logic match;
  logic [CNT_W-1:0] cnt_inc;
  always_comb begin
    nxt_raw = TBL[{st, x}];
    match = en && (nxt_raw == FULL);
    st_nxt = !en ? st : (match && !MOORE) ? (OVERLAP ? FAIL : '0) : nxt_raw;
    y = MOORE ? (st == FULL) : (match && !reset);
    cnt_inc = match_count + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= '0;
    else st <= st_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      match_count <= '0;
      cnt_sat <= 1'b0;
    end else if (clr_cnt) begin
      match_count <= '0;
      cnt_sat <= 1'b0;
    end else if (match && !cnt_sat) begin
      match_count <= cnt_inc;
      cnt_sat <= &cnt_inc;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern-detector FSM. It is the generalised successor of the fixed single-pattern x/y detector. It consumes one input bit per enabled clock and flags when a programmable PATTERN of PAT_LEN bits has been received. Overlap and Moore/Mealy output style are compile-time modes, and a saturating match counter is included. It sits on serial control/test streams and is driven by the same generator-produced benches as the existing FSMs.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 1..32; elaboration error outside that range.
PATTERN, 4'b1011, pattern to detect, PAT_LEN bits wide; MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = detection restarts from empty after each match.
MOORE, 1, 1 = registered Moore output; 0 = combinational Mealy output.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  bit-valid qualifier; x is sampled only when en=1
x  input  1  serial data bit
clr_cnt  input  1  synchronous clear of match_count and cnt_sat
y  output  1  match indication
match_count  output  CNT_W  number of matches since reset or clear; saturating
cnt_sat  output  1  high while match_count equals all-ones

Behaviour:
- State register: st in 0..PAT_LEN, equal to the number of pattern prefix bits currently matched. Width is clog2(PAT_LEN+1).
- Next-state rule (en=1): next st = length of the longest PATTERN prefix that is a suffix of (matched prefix followed by x). This is the KMP failure-function style transition.
  - The transition table is computed at elaboration by a constant function.
  - There is no runtime search logic.
- Match event: en=1 and the current bit completes the pattern, i.e. next-state computation yields PAT_LEN.
- OVERLAP=1, after a match:
  - Moore: st=PAT_LEN, and the next bit is evaluated from that state using the failure transitions.
  - Mealy: st holds failure(PAT_LEN).
- OVERLAP=0, after a match: the following bit is evaluated from st=0.
  - Moore: st=PAT_LEN is held for the output cycle; its outgoing transitions equal those of st=0.
  - Mealy: st goes directly to 0.
- en=0: st holds and x is ignored.
  - Moore: y holds its value, since y is a pure function of st.
  - Mealy: y=0.
- MOORE=1: y = (st==PAT_LEN). y rises one clock after the edge that accepts the final bit, and stays high until the next enabled bit moves st away.
- MOORE=0: y = match event, combinational from en, x and st, in the same cycle as the final bit.
- Counter: increments by 1 on each match event. It saturates at 2^CNT_W-1 with no wrap; further matches are ignored. cnt_sat = (match_count == all-ones), registered alongside the count.
- clr_cnt=1: match_count and cnt_sat go to 0 at the next edge. clr_cnt has priority over a simultaneous match event, which is not counted. st and y are unaffected.
- Reset (asynchronous, any time, including mid-sequence):
  - st=0, match_count=0, cnt_sat=0 immediately, with no clock required.
  - Moore: y=0 immediately.
  - Mealy: y is gated to 0 while reset=1.
  - Partial prefix progress is discarded.
- PAT_LEN=1: every enabled bit equal to PATTERN[0] is a match. The OVERLAP setting has no effect.

Test Plan:
1. MOORE=1, OVERLAP=1, PATTERN=1011; reset then enabled x = 1,0,1,1,0,1,1 -> y high in the cycle after bit 4 and after bit 7; match_count=2.
2. MOORE=1, OVERLAP=0, same stream -> y high only after bit 4; bits 5..7 (0,1,1) give no match; match_count=1.
3. MOORE=0, OVERLAP=1, stream 1,0,1,1 -> y=1 combinationally during the bit-4 cycle with en=1; y=0 in all other cycles; count=1.
4. en gaps: 1,(en=0,x=0),0,(en=0,x=1),1,1 -> the gap bits are ignored; a match occurs on the final 1; with MOORE=1, y holds high through a subsequent en=0 cycle.
5. CNT_W=2, feed 5 matches -> match_count=3 and cnt_sat=1 after the 3rd match, and remains 3; clr_cnt with a simultaneous match -> count=0, cnt_sat=0.
6. Feed 1,0,1, assert reset asynchronously mid-cycle -> st=0 and y=0 without a clock edge; release reset, feed 1 -> no match; full 1,0,1,1 -> match.
